// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter sharing one FIFO write port among
// NUM_REQ valid/ready producers. A grant lasts until packet end, burst
// limit or idle timeout, and is always followed by one IDLE bubble.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no owner; arbitrate from rr_ptr when FIFO is not almost full
//   S_GRANT | grant_id owns the write port; beats forwarded while not full
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BURST  = 16,
   parameter int TIMEOUT    = 0,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          sclr,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   input  logic                          fifo_afull,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic                          grant_valid,
   output logic [ID_W-1:0]               grant_id,
   output logic                          timeout_pulse
);

   localparam int BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
   localparam int IC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(MAX_BURST - 1);
   localparam logic [IC_W-1:0] IDLE_LAST = IC_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [ID_W-1:0] ID_MAX    = ID_W'(NUM_REQ - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          state, state_nx;
   logic [ID_W-1:0] gid_nx, rr_ptr, rr_nx, rr_after, pick_id;
   logic [BC_W-1:0] beat_cnt, beat_nx;
   logic [IC_W-1:0] idle_cnt, idle_nx;
   logic            in_grant, cur_valid, cur_last, accept, stall;
   logic            timeout_hit, rel, pick_found;

   // Granted-producer datapath: ready, write enable, data mux, release decision
   always_comb begin
      in_grant     = (state == S_GRANT);
      cur_valid    = req_valid[grant_id];
      cur_last     = req_last[grant_id];
      fifo_data_in = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
      accept       = in_grant & cur_valid & ~fifo_full;
      stall        = in_grant & ~cur_valid;
      timeout_hit  = (TIMEOUT != 0) && stall && (idle_cnt == IDLE_LAST);
      rel          = (accept & (cur_last | (beat_cnt == BEAT_LAST))) | timeout_hit;
      rr_after     = (grant_id == ID_MAX) ? '0 : grant_id + 1'b1;
      req_ready    = '0;
      if (in_grant && !fifo_full) req_ready[grant_id] = 1'b1;
      fifo_wr_en    = accept;
      grant_valid   = in_grant;
      timeout_pulse = timeout_hit;
   end

   // Round-robin search: first valid requester at or after rr_ptr, wrapping
   always_comb begin : arb
      int idx;
      idx        = 0;
      pick_found = 1'b0;
      pick_id    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!pick_found && req_valid[idx]) begin
            pick_found = 1'b1;
            pick_id    = ID_W'(idx);
         end
      end
   end

   // Next-state and counter updates
   always_comb begin
      state_nx = state;
      gid_nx   = grant_id;
      rr_nx    = rr_ptr;
      beat_nx  = beat_cnt;
      idle_nx  = idle_cnt;
      case (state)
         S_IDLE: begin
            if (pick_found && !fifo_afull) begin
               state_nx = S_GRANT;
               gid_nx   = pick_id;
               beat_nx  = '0;
               idle_nx  = '0;
            end
         end
         S_GRANT: begin
            if (accept) begin
               beat_nx = beat_cnt + 1'b1;
               idle_nx = '0;
            end else if (stall) begin
               idle_nx = idle_cnt + 1'b1;
            end
            if (rel) begin
               state_nx = S_IDLE;
               rr_nx    = rr_after;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State registers; sclr behaves as a one-cycle synchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         idle_cnt <= '0;
      end else if (sclr) begin
         state    <= S_IDLE;
         grant_id <= '0;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         idle_cnt <= '0;
      end else begin
         state    <= state_nx;
         grant_id <= gid_nx;
         rr_ptr   <= rr_nx;
         beat_cnt <= beat_nx;
         idle_cnt <= idle_nx;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=16, TIMEOUT=4).
// Inputs change 1 time unit after a rising edge, outputs are sampled 1 unit later.
module tb_fifo_wr_arbiter;

   logic         clk = 1'b0;
   logic         rst, sclr;
   logic [3:0]   req_valid, req_last, req_ready;
   logic [127:0] req_data;
   logic         fifo_full, fifo_afull, fifo_wr_en;
   logic [31:0]  fifo_data_in;
   logic         grant_valid, timeout_pulse;
   logic [1:0]   grant_id;

   int total  = 0;
   int passed = 0;

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .MAX_BURST(16), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .sclr(sclr),
      .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready),
      .fifo_full(fifo_full), .fifo_afull(fifo_afull),
      .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
      .grant_valid(grant_valid), .grant_id(grant_id),
      .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_data(input int i, input logic [31:0] v);
      req_data[i*32 +: 32] = v;
   endtask

   task automatic test_reset();
      rst = 1'b1; sclr = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
      fifo_full = 1'b0; fifo_afull = 1'b0;
      #2;
      total++;
      if ({req_ready, fifo_wr_en, grant_valid, grant_id, timeout_pulse} !== 9'b0)
         $display("FAIL reset_outputs got %b exp 0",
                  {req_ready, fifo_wr_en, grant_valid, grant_id, timeout_pulse});
      else passed++;
      req_valid = 4'hF;
      tick();
      total++;
      if ({req_ready, fifo_wr_en, grant_valid, grant_id} !== 8'b0)
         $display("FAIL reset_hold got %b exp 0", {req_ready, fifo_wr_en, grant_valid, grant_id});
      else passed++;
      req_valid = '0;
      rst = 1'b0;
   endtask

   // All four producers send 1-beat packets: grants rotate 0,1,2,3,0,1 with bubbles
   task automatic test_round_robin();
      req_valid = 4'hF; req_last = 4'hF;
      for (int i = 0; i < 4; i++) set_data(i, 32'hA000_0000 + i);
      for (int k = 0; k < 6; k++) begin
         #1;
         total++;
         if ({grant_valid, fifo_wr_en} !== 2'b00)
            $display("FAIL rr_bubble k=%0d got %b exp 00", k, {grant_valid, fifo_wr_en});
         else passed++;
         tick();
         #1;
         total++;
         if ({grant_valid, grant_id, fifo_wr_en, req_ready} !==
             {1'b1, 2'(k % 4), 1'b1, 4'(1 << (k % 4))})
            $display("FAIL rr_grant k=%0d got %b exp %b", k,
                     {grant_valid, grant_id, fifo_wr_en, req_ready},
                     {1'b1, 2'(k % 4), 1'b1, 4'(1 << (k % 4))});
         else passed++;
         total++;
         if (fifo_data_in !== 32'hA000_0000 + 32'(k % 4))
            $display("FAIL rr_data k=%0d got %h exp %h", k, fifo_data_in, 32'hA000_0000 + 32'(k % 4));
         else passed++;
         tick();
      end
      req_valid = '0;
   endtask

   // rr_ptr=2: producer 2 sends 5 beats while 0 and 1 wait; 3 idle so 0 is next
   task automatic test_packet();
      req_valid = 4'b0111; req_last = 4'b0011;
      set_data(0, 32'h0000_0B0B);
      #1;
      total++;
      if (grant_valid !== 1'b0) $display("FAIL pkt_bubble0 got %b exp 0", grant_valid);
      else passed++;
      tick();
      for (int b = 0; b < 5; b++) begin
         req_last[2] = (b == 4);
         set_data(2, 32'h2000_0000 + b);
         #1;
         total++;
         if ({grant_valid, grant_id, fifo_wr_en, req_ready} !== {1'b1, 2'd2, 1'b1, 4'b0100})
            $display("FAIL pkt_beat b=%0d got %b exp %b", b,
                     {grant_valid, grant_id, fifo_wr_en, req_ready}, {1'b1, 2'd2, 1'b1, 4'b0100});
         else passed++;
         total++;
         if (fifo_data_in !== 32'h2000_0000 + 32'(b))
            $display("FAIL pkt_data b=%0d got %h exp %h", b, fifo_data_in, 32'h2000_0000 + 32'(b));
         else passed++;
         tick();
      end
      #1;
      total++;
      if ({grant_valid, fifo_wr_en} !== 2'b00)
         $display("FAIL pkt_bubble1 got %b exp 00", {grant_valid, fifo_wr_en});
      else passed++;
      tick();
      #1;
      total++;
      if ({grant_valid, grant_id, fifo_wr_en, fifo_data_in} !== {1'b1, 2'd0, 1'b1, 32'h0000_0B0B})
         $display("FAIL pkt_next got gv=%b id=%0d wr=%b d=%h exp gv=1 id=0 wr=1 d=00000b0b",
                  grant_valid, grant_id, fifo_wr_en, fifo_data_in);
      else passed++;
      tick();
      req_valid = '0;
   endtask

   // rr_ptr=1: producer 1 streams without last, cut at 16 beats; then 2, 0, 1
   task automatic test_burst_limit();
      logic [1:0] order [2];
      order = '{2'd2, 2'd0};
      req_valid = 4'b0111; req_last = 4'b0101;
      #1;
      total++;
      if (grant_valid !== 1'b0) $display("FAIL burst_bubble0 got %b exp 0", grant_valid);
      else passed++;
      tick();
      for (int b = 0; b < 16; b++) begin
         set_data(1, 32'h1000_0000 + b);
         #1;
         total++;
         if ({grant_valid, grant_id, fifo_wr_en, fifo_data_in} !==
             {1'b1, 2'd1, 1'b1, 32'h1000_0000 + 32'(b)})
            $display("FAIL burst_beat b=%0d got gv=%b id=%0d wr=%b d=%h exp 1/1/1/%h", b,
                     grant_valid, grant_id, fifo_wr_en, fifo_data_in, 32'h1000_0000 + 32'(b));
         else passed++;
         tick();
      end
      for (int j = 0; j < 2; j++) begin
         #1;
         total++;
         if (grant_valid !== 1'b0) $display("FAIL burst_release j=%0d got %b exp 0", j, grant_valid);
         else passed++;
         tick();
         #1;
         total++;
         if ({grant_valid, grant_id, fifo_wr_en} !== {1'b1, order[j], 1'b1})
            $display("FAIL burst_order j=%0d got %b exp %b", j,
                     {grant_valid, grant_id, fifo_wr_en}, {1'b1, order[j], 1'b1});
         else passed++;
         tick();
      end
      #1;
      total++;
      if (grant_valid !== 1'b0) $display("FAIL burst_bubble2 got %b exp 0", grant_valid);
      else passed++;
      tick();
      total++;
      if ({grant_valid, grant_id} !== 3'b101)
         $display("FAIL burst_regrant got %b exp 101", {grant_valid, grant_id});
      else passed++;
   endtask

   // Producer 1 holds the grant and goes quiet: pulse in 4th idle cycle
   task automatic test_timeout();
      req_valid = '0;
      for (int t = 0; t < 4; t++) begin
         #1;
         total++;
         if ({grant_valid, grant_id, fifo_wr_en, timeout_pulse} !== {1'b1, 2'd1, 1'b0, (t == 3)})
            $display("FAIL tmo_idle t=%0d got %b exp %b", t,
                     {grant_valid, grant_id, fifo_wr_en, timeout_pulse}, {1'b1, 2'd1, 1'b0, (t == 3)});
         else passed++;
         tick();
      end
      #1;
      total++;
      if ({grant_valid, timeout_pulse} !== 2'b00)
         $display("FAIL tmo_release got %b exp 00", {grant_valid, timeout_pulse});
      else passed++;
   endtask

   // afull blocks arbitration; mid-packet fifo_full stalls for 3 cycles
   task automatic test_full_afull();
      logic full_v [7];
      logic afull_v [7];
      int   bidx [7];
      int   nwr;
      full_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      afull_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      bidx    = '{0, 1, 2, 2, 2, 2, 3};
      nwr     = 0;
      req_valid = 4'b1000; req_last = '0; fifo_afull = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if ({grant_valid, fifo_wr_en} !== 2'b00)
            $display("FAIL afull_block c=%0d got %b exp 00", c, {grant_valid, fifo_wr_en});
         else passed++;
      end
      fifo_afull = 1'b0;
      tick();
      for (int c = 0; c < 7; c++) begin
         fifo_full  = full_v[c];
         fifo_afull = afull_v[c];
         req_last[3] = (bidx[c] == 3);
         set_data(3, 32'h3000_0000 + bidx[c]);
         #1;
         total++;
         if ({grant_valid, grant_id, fifo_wr_en, req_ready} !==
             {1'b1, 2'd3, ~full_v[c], (full_v[c] ? 4'b0000 : 4'b1000)})
            $display("FAIL full_cycle c=%0d got %b exp %b", c,
                     {grant_valid, grant_id, fifo_wr_en, req_ready},
                     {1'b1, 2'd3, ~full_v[c], (full_v[c] ? 4'b0000 : 4'b1000)});
         else passed++;
         if (fifo_wr_en) begin
            total++;
            if (fifo_data_in !== 32'h3000_0000 + 32'(nwr))
               $display("FAIL full_seq c=%0d got %h exp %h", c, fifo_data_in, 32'h3000_0000 + 32'(nwr));
            else passed++;
            nwr++;
         end
         tick();
      end
      fifo_full = 1'b0; fifo_afull = 1'b0;
      #1;
      total++;
      if ({grant_valid, nwr} !== {1'b0, 32'd4})
         $display("FAIL full_end got gv=%b writes=%0d exp gv=0 writes=4", grant_valid, nwr);
      else passed++;
      req_valid = '0;
   endtask

   // Asynchronous rst mid-packet, then arbitration restarts at producer 0
   task automatic test_async_reset();
      req_valid = 4'b0010; req_last = '0;
      tick();
      tick();
      total++;
      if ({grant_valid, grant_id, fifo_wr_en} !== 4'b1011)
         $display("FAIL arst_pre got %b exp 1011", {grant_valid, grant_id, fifo_wr_en});
      else passed++;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({req_ready, fifo_wr_en, grant_valid, grant_id, timeout_pulse} !== 9'b0)
         $display("FAIL arst_now got %b exp 0",
                  {req_ready, fifo_wr_en, grant_valid, grant_id, timeout_pulse});
      else passed++;
      #1 rst = 1'b0;
      req_valid = 4'b0011; req_last = 4'b0001;
      tick();
      total++;
      if ({grant_valid, grant_id, fifo_wr_en} !== 4'b1001)
         $display("FAIL arst_restart got %b exp 1001", {grant_valid, grant_id, fifo_wr_en});
      else passed++;
      tick();
   endtask

   // rr_ptr=1: grant 1 mid-packet, sclr takes effect at the next edge
   task automatic test_sclr();
      req_valid = 4'b0011; req_last = '0;
      tick();
      total++;
      if ({grant_valid, grant_id, fifo_wr_en} !== 4'b1011)
         $display("FAIL sclr_pre got %b exp 1011", {grant_valid, grant_id, fifo_wr_en});
      else passed++;
      #1 sclr = 1'b1;
      #1;
      total++;
      if (grant_valid !== 1'b1) $display("FAIL sclr_sync got %b exp 1", grant_valid);
      else passed++;
      tick();
      sclr = 1'b0;
      #1;
      total++;
      if ({grant_valid, grant_id, req_ready, fifo_wr_en} !== 8'b0)
         $display("FAIL sclr_clear got %b exp 0", {grant_valid, grant_id, req_ready, fifo_wr_en});
      else passed++;
      tick();
      total++;
      if ({grant_valid, grant_id} !== 3'b100)
         $display("FAIL sclr_restart got %b exp 100", {grant_valid, grant_id});
      else passed++;
      req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_packet();
      test_burst_limit();
      test_timeout();
      test_full_afull();
      test_async_reset();
      test_sclr();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
      $fatal(1);
   end

endmodule
